// File: rtl/wake_pkg.sv
// Shared definitions for the wake sequencer: default timing parameters,
// FSM state encoding, register addresses and register bit positions.
package wake_pkg;

  localparam int DEF_WFI_DEBOUNCE  = 4;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_TIMER_W       = 24;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_ARM    = 3'd1,
    ST_SLEEP  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAKE   = 3'd4
  } wake_state_t;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_TIMER_LOAD = 2'd1;
  localparam logic [1:0] ADDR_STATUS     = 2'd2;
  localparam logic [1:0] ADDR_COUNT      = 2'd3;

  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_EXT_EN   = 1;
  localparam int STAT_TIMER    = 0;
  localparam int STAT_EXT      = 1;

endpackage

// File: rtl/wake_sync.sv
// Two-flop synchroniser for an asynchronous pin followed by a rising-edge
// detector; pulse is high for exactly one clk cycle per synchronised edge.
module wake_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;

  // Shift the pin through two metastability flops plus one edge-history flop.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], async_in};
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/wake_ctrl.sv
// Sleep/wake sequencer: debounces the CPU idle flag, gates the core clock,
// wakes on the wake timer or the external pin, and raises wake_irq once the
// PLL has held lock for SETTLE_CYCLES consecutive cycles.
//
//  state  | meaning
//  RUN    | core clock running, watching wfi
//  ARM    | one cycle: load the wake timer, confirm wfi still high
//  SLEEP  | core clock gated, waiting for a wake event
//  SETTLE | clock ungated, waiting for a stable PLL lock
//  WAKE   | wake_irq asserted until the CPU drops wfi
module wake_ctrl
  import wake_pkg::*;
#(
  parameter int WFI_DEBOUNCE  = DEF_WFI_DEBOUNCE,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMER_W       = DEF_TIMER_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wfi,
  input  logic        ext_wake,
  input  logic        pll_lock,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        clk_gate,
  output logic        wake_irq
);

  localparam int WFI_W = $clog2(WFI_DEBOUNCE) + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [WFI_W-1:0] WFI_LAST = WFI_W'(WFI_DEBOUNCE - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  wake_state_t        state, next_state;
  logic [WFI_W-1:0]   wfi_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [TIMER_W-1:0] timer_cnt;
  logic [TIMER_W-1:0] timer_load;
  logic [1:0]         ctrl;
  logic [1:0]         status;
  logic [1:0]         status_set;
  logic [1:0]         status_clr;
  logic [31:0]        rdata_nxt;
  logic               ext_evt;
  logic               timer_en, ext_en;
  logic               timer_hit, ext_hit, wake_evt;
  logic               wfi_ok;
  logic               clk_gate_nxt, wake_irq_nxt;
  logic               unused_wdata;

  assign unused_wdata = &{1'b0, cfg_wdata[31:TIMER_W]};

  wake_sync u_ext_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ext_wake),
    .pulse    (ext_evt)
  );

  assign timer_en  = ctrl[CTRL_TIMER_EN];
  assign ext_en    = ctrl[CTRL_EXT_EN];
  assign timer_hit = timer_en && (timer_cnt == '0);
  assign ext_hit   = ext_en && ext_evt;
  assign wfi_ok    = wfi && (wfi_cnt == WFI_LAST);

  // Count consecutive wfi=1 cycles before the current one, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n || !wfi)         wfi_cnt <= '0;
    else if (wfi_cnt != WFI_LAST) wfi_cnt <= wfi_cnt + 1'b1;
  end

  // State register; outputs are registered from next_state so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      clk_gate <= 1'b0;
      wake_irq <= 1'b0;
    end else begin
      state    <= next_state;
      clk_gate <= clk_gate_nxt;
      wake_irq <= wake_irq_nxt;
    end
  end

  // Next-state decision.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:    if (wfi_ok && (timer_en || ext_en)) next_state = ST_ARM;
      ST_ARM:    next_state = wfi ? ST_SLEEP : ST_RUN;
      ST_SLEEP:  if (wake_evt) next_state = ST_SETTLE;
      ST_SETTLE: if (pll_lock && (settle_cnt == SET_LAST)) next_state = ST_WAKE;
      ST_WAKE:   if (!wfi) next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
  end

  // Output decode from the state being entered.
  always_comb begin
    clk_gate_nxt = (next_state == ST_SLEEP);
    wake_irq_nxt = (next_state == ST_WAKE);
  end

  // Wake causes seen this cycle; only meaningful while sleeping.
  always_comb begin
    status_set = '0;
    if (state == ST_SLEEP) begin
      status_set[STAT_TIMER] = timer_hit;
      status_set[STAT_EXT]   = ext_hit;
    end
    wake_evt   = |status_set;
    status_clr = (cfg_we && (cfg_addr == ADDR_STATUS)) ? cfg_wdata[1:0] : 2'b00;
  end

  // Wake timer: loaded in ARM, counts down to zero while sleeping with the timer enabled.
  always_ff @(posedge clk) begin
    if (!rst_n)
      timer_cnt <= '0;
    else if (state == ST_ARM)
      timer_cnt <= timer_load;
    else if ((state == ST_SLEEP) && timer_en && (timer_cnt != '0))
      timer_cnt <= timer_cnt - 1'b1;
  end

  // Settle counter: consecutive locked cycles in SETTLE, restarts on any lock drop.
  always_ff @(posedge clk) begin
    if (!rst_n || (state != ST_SETTLE) || !pll_lock) settle_cnt <= '0;
    else                                             settle_cnt <= settle_cnt + 1'b1;
  end

  // Register file; a new cause in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl       <= '0;
      timer_load <= '0;
      status     <= '0;
    end else begin
      if (cfg_we && (cfg_addr == ADDR_CTRL))       ctrl       <= cfg_wdata[1:0];
      if (cfg_we && (cfg_addr == ADDR_TIMER_LOAD)) timer_load <= cfg_wdata[TIMER_W-1:0];
      status <= (status & ~status_clr) | status_set;
    end
  end

  // Read mux over the current register values.
  always_comb begin
    rdata_nxt = '0;
    case (cfg_addr)
      ADDR_CTRL:       rdata_nxt = {30'd0, ctrl};
      ADDR_TIMER_LOAD: rdata_nxt = 32'(timer_load);
      ADDR_STATUS:     rdata_nxt = {30'd0, status};
      ADDR_COUNT:      rdata_nxt = 32'(timer_cnt);
      default:         rdata_nxt = '0;
    endcase
  end

  // Registered read data, one cycle behind the address.
  always_ff @(posedge clk) begin
    if (!rst_n) cfg_rdata <= '0;
    else        cfg_rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_wake_ctrl.sv
// Bench for wake_ctrl: register table, directed wake scenarios and a
// randomized run, all cross-checked against a cycle-level reference model.
module tb_wake_ctrl;
  import wake_pkg::*;

  localparam int DEBOUNCE = 4;
  localparam int SETTLE   = 16;

  logic        clk = 1'b0;
  logic        rst_n, wfi, ext_wake, pll_lock, cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        clk_gate, wake_irq;

  always #5 clk = ~clk;

  wake_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wfi       (wfi),
    .ext_wake  (ext_wake),
    .pll_lock  (pll_lock),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .clk_gate  (clk_gate),
    .wake_irq  (wake_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases of the sleep sequence tracked with plain counters.
  localparam int P_RUN = 0, P_ARM = 1, P_SLEEP = 2, P_SETTLE = 3, P_WAKE = 4;
  int          m_phase, m_streak, m_lock_run;
  logic [1:0]  m_ctrl, m_status;
  logic [23:0] m_load, m_count;
  logic [2:0]  m_pin_hist;
  logic [31:0] m_rdata;

  task automatic model_edge();
    logic        evt;
    logic [1:0]  set, clr;
    logic [31:0] rd;
    if (!rst_n) begin
      m_phase = P_RUN; m_streak = 0; m_lock_run = 0;
      m_ctrl = 0; m_status = 0; m_load = 0; m_count = 0;
      m_pin_hist = 0; m_rdata = 0;
      return;
    end
    evt = m_pin_hist[1] & ~m_pin_hist[2];
    case (cfg_addr)
      2'd0:    rd = {30'd0, m_ctrl};
      2'd1:    rd = {8'd0, m_load};
      2'd2:    rd = {30'd0, m_status};
      default: rd = {8'd0, m_count};
    endcase
    m_streak = wfi ? m_streak + 1 : 0;
    set = 2'b00;
    clr = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[1:0] : 2'b00;
    case (m_phase)
      P_RUN:  if (m_streak >= DEBOUNCE && m_ctrl != 0) m_phase = P_ARM;
      P_ARM: begin
        m_count = m_load;
        m_phase = wfi ? P_SLEEP : P_RUN;
      end
      P_SLEEP: begin
        if (m_ctrl[0] && m_count == 0) set[0] = 1'b1;
        if (m_ctrl[1] && evt)          set[1] = 1'b1;
        if (m_ctrl[0] && m_count != 0) m_count = m_count - 1;
        if (set != 0) begin
          m_phase = P_SETTLE;
          m_lock_run = 0;
        end
      end
      P_SETTLE: begin
        m_lock_run = pll_lock ? m_lock_run + 1 : 0;
        if (m_lock_run == SETTLE) m_phase = P_WAKE;
      end
      default: if (!wfi) m_phase = P_RUN;
    endcase
    if (cfg_we && cfg_addr == 2'd0) m_ctrl = cfg_wdata[1:0];
    if (cfg_we && cfg_addr == 2'd1) m_load = cfg_wdata[23:0];
    m_status   = (m_status & ~clr) | set;
    m_pin_hist = {m_pin_hist[1:0], ext_wake};
    m_rdata    = rd;
  endtask

  // One clock: advance DUT and model, compare all outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("clk_gate", {31'd0, clk_gate}, {31'd0, m_phase == P_SLEEP});
    check("wake_irq", {31'd0, wake_irq}, {31'd0, m_phase == P_WAKE});
    check("cfg_rdata", cfg_rdata, m_rdata);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_we = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic cfg_read(input logic [1:0] addr, input string name, input logic [31:0] exp);
    cfg_addr = addr;
    step();
    check(name, cfg_rdata, exp);
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? clk_gate : wake_irq;
  endfunction

  // Step until clk_gate (which=0) or wake_irq (which=1) equals val; n = steps taken.
  task automatic wait_for(input int which, input logic val, input int max,
                          input string name, output int n);
    n = 0;
    while (sig(which) !== val && n < max) begin
      step();
      n++;
    end
    if (sig(which) !== val) check({name, "_timeout"}, {31'd0, sig(which)}, {31'd0, val});
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gated;
    rst_n = 1'b0; wfi = 1'b0; ext_wake = 1'b0; pll_lock = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    step(); step();
    check("reset_clk_gate", {31'd0, clk_gate}, 32'd0);
    check("reset_wake_irq", {31'd0, wake_irq}, 32'd0);
    check("reset_rdata", cfg_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Register access table: rdata after each edge shows the pre-write value.
    tbl[0]  = '{1'b1, ADDR_CTRL,       32'hFFFF_FFFF, 32'h0000_0000};
    tbl[1]  = '{1'b0, ADDR_CTRL,       32'h0,         32'h0000_0003};
    tbl[2]  = '{1'b1, ADDR_TIMER_LOAD, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3]  = '{1'b0, ADDR_TIMER_LOAD, 32'h0,         32'h00FF_FFFF};
    tbl[4]  = '{1'b1, ADDR_COUNT,      32'h0000_1234, 32'h0000_0000};
    tbl[5]  = '{1'b0, ADDR_COUNT,      32'h0,         32'h0000_0000};
    tbl[6]  = '{1'b1, ADDR_STATUS,     32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7]  = '{1'b0, ADDR_STATUS,     32'h0,         32'h0000_0000};
    tbl[8]  = '{1'b1, ADDR_TIMER_LOAD, 32'h0000_0064, 32'h00FF_FFFF};
    tbl[9]  = '{1'b0, ADDR_TIMER_LOAD, 32'h0,         32'h0000_0064};
    tbl[10] = '{1'b1, ADDR_CTRL,       32'h0,         32'h0000_0003};
    tbl[11] = '{1'b0, ADDR_CTRL,       32'h0,         32'h0000_0000};
    for (int i = 0; i < 12; i++) begin
      cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
      step();
      check($sformatf("vec%0d", i), cfg_rdata, tbl[i].exp_rdata);
    end
    cfg_we = 1'b0;

    // Timer wake.
    cfg_write(ADDR_CTRL, 32'd1);
    cfg_write(ADDR_TIMER_LOAD, 32'd100);
    wfi = 1'b1;
    wait_for(0, 1'b1, 20, "t1_gate_up", n);
    check("t1_cycles_to_gate", n, 5);
    wait_for(0, 1'b0, 200, "t1_gate_down", n);
    check("t1_sleep_cycles", n, 101);
    repeat (3) step();
    pll_lock = 1'b1;
    wait_for(1, 1'b1, 40, "t1_irq", n);
    check("t1_settle_cycles", n, SETTLE);
    cfg_read(ADDR_STATUS, "t1_status", 32'd1);
    wfi = 1'b0;
    step();
    check("t1_irq_clear", {31'd0, wake_irq}, 32'd0);
    cfg_write(ADDR_STATUS, 32'd1);
    cfg_read(ADDR_STATUS, "t1_status_w1c", 32'd0);

    // External wake.
    cfg_write(ADDR_CTRL, 32'd2);
    wfi = 1'b1;
    wait_for(0, 1'b1, 20, "t2_gate_up", n);
    repeat (5) step();
    ext_wake = 1'b1;
    wait_for(0, 1'b0, 10, "t2_gate_down", n);
    check("t2_pin_to_ungate", n, 3);
    ext_wake = 1'b0;
    wait_for(1, 1'b1, 40, "t2_irq", n);
    check("t2_settle_cycles", n, SETTLE);
    cfg_read(ADDR_STATUS, "t2_status", 32'd2);
    wfi = 1'b0;
    step();
    check("t2_irq_clear_same_cycle", {31'd0, wake_irq}, 32'd0);
    cfg_write(ADDR_STATUS, 32'd3);

    // Lock glitch during settle.
    cfg_write(ADDR_CTRL, 32'd1);
    cfg_write(ADDR_TIMER_LOAD, 32'd5);
    wfi = 1'b1;
    wait_for(0, 1'b1, 20, "t3_gate_up", n);
    wait_for(0, 1'b0, 20, "t3_gate_down", n);
    repeat (10) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    wait_for(1, 1'b1, 40, "t3_irq", n);
    check("t3_settle_after_glitch", n, SETTLE);
    wfi = 1'b0;
    step();
    cfg_write(ADDR_STATUS, 32'd3);

    // No wake source, then short wfi bursts.
    cfg_write(ADDR_CTRL, 32'd0);
    wfi = 1'b1;
    gated = 0;
    repeat (1000) begin
      step();
      if (clk_gate) gated++;
    end
    check("t4_no_source_gated", gated, 0);
    wfi = 1'b0;
    cfg_write(ADDR_CTRL, 32'd1);
    cfg_write(ADDR_TIMER_LOAD, 32'd0);
    gated = 0;
    repeat (5) begin
      wfi = 1'b1;
      repeat (DEBOUNCE - 1) begin step(); if (clk_gate) gated++; end
      wfi = 1'b0;
      step();
      if (clk_gate) gated++;
    end
    check("t4_short_wfi_gated", gated, 0);

    // Simultaneous timer and external causes on the first sleep cycle.
    cfg_write(ADDR_CTRL, 32'd3);
    wfi = 1'b1;
    repeat (3) step();
    ext_wake = 1'b1;
    repeat (2) step();
    check("t5_gate_up", {31'd0, clk_gate}, 32'd1);
    step();
    check("t5_wake_first_sleep_cycle", {31'd0, clk_gate}, 32'd0);
    ext_wake = 1'b0;
    wait_for(1, 1'b1, 40, "t5_irq", n);
    cfg_read(ADDR_STATUS, "t5_status_both", 32'd3);
    wfi = 1'b0;
    step();
    cfg_write(ADDR_STATUS, 32'd3);
    cfg_read(ADDR_STATUS, "t5_status_cleared", 32'd0);
    // Clear of bit0 on the very edge the timer cause is set.
    cfg_write(ADDR_CTRL, 32'd1);
    wfi = 1'b1;
    wait_for(0, 1'b1, 20, "t5b_gate_up", n);
    cfg_we = 1'b1; cfg_addr = ADDR_STATUS; cfg_wdata = 32'd1;
    step();
    cfg_we = 1'b0;
    check("t5b_wake", {31'd0, clk_gate}, 32'd0);
    cfg_read(ADDR_STATUS, "t5b_set_wins", 32'd1);
    wait_for(1, 1'b1, 40, "t5b_irq", n);
    wfi = 1'b0;
    step();
    cfg_write(ADDR_STATUS, 32'd3);

    // Reset in the middle of SLEEP.
    cfg_write(ADDR_TIMER_LOAD, 32'd1000);
    wfi = 1'b1;
    wait_for(0, 1'b1, 20, "t6_gate_up", n);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    check("t6_clk_gate", {31'd0, clk_gate}, 32'd0);
    check("t6_wake_irq", {31'd0, wake_irq}, 32'd0);
    check("t6_rdata", cfg_rdata, 32'd0);
    rst_n = 1'b1; wfi = 1'b0;
    cfg_read(ADDR_CTRL, "t6_ctrl", 32'd0);
    cfg_read(ADDR_TIMER_LOAD, "t6_load", 32'd0);
    cfg_read(ADDR_COUNT, "t6_count", 32'd0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) wfi = ~wfi;
      if ($urandom_range(0, 24) == 0) ext_wake = ~ext_wake;
      pll_lock  = ($urandom_range(0, 31) != 0);
      rst_n     = ($urandom_range(0, 999) != 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_we    = ($urandom_range(0, 29) == 0);
      cfg_wdata = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 60));
      step();
    end
    rst_n = 1'b1; cfg_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
